// File: rtl/obuf_stream_reader_if.sv
// Handshake bundle between the output FIFO, the stream reader and the display stage.
// master = the reader; slave = the FIFO/display side that drives the inputs.
interface obuf_stream_reader_if;
    logic [15:0] i_obuf_data;
    logic        i_obuf_empty;
    logic        i_obuf_almostempty;
    logic        o_obuf_rd;
    logic [15:0] o_tdata;
    logic        o_tvalid;
    logic        i_tready;
    logic        o_tuser;
    logic        o_tlast;

    modport master (
        input  i_obuf_data,
        input  i_obuf_empty,
        input  i_obuf_almostempty,
        input  i_tready,
        output o_obuf_rd,
        output o_tdata,
        output o_tvalid,
        output o_tuser,
        output o_tlast
    );

    modport slave (
        output i_obuf_data,
        output i_obuf_empty,
        output i_obuf_almostempty,
        output i_tready,
        input  o_obuf_rd,
        input  o_tdata,
        input  o_tvalid,
        input  o_tuser,
        input  o_tlast
    );
endinterface

// File: rtl/obuf_stream_reader.sv
// Drains the core's output FIFO into a framed valid/ready pixel stream through a
// 3-entry skid buffer that covers the FIFO's one-cycle read latency.
module obuf_stream_reader #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_flush,
    obuf_stream_reader_if.master        bus,
    output logic                        o_frame_done,
    output logic [15:0]                 o_starve_cnt
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    localparam logic [9:0] XLast = 10'(IMG_WIDTH - 1);
    localparam logic [8:0] YLast = 9'(IMG_HEIGHT - 1);

    state_e      state_q, state_d;
    logic [15:0] buf_q [3];
    logic [1:0]  head_q, tail_q, occ_q, occ_d;
    logic        inflight_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic        frame_done_q;
    logic [15:0] starve_q;

    logic clear, rd, valid, push, pop, x_last, y_last, starve;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign clear  = !i_rstn || i_flush;
    assign valid  = (occ_q != 2'd0);
    assign push   = inflight_q;
    assign pop    = valid && bus.i_tready;
    assign x_last = (x_q == XLast);
    assign y_last = (y_q == YLast);
    assign starve = (state_q == StStream) && bus.i_tready && !valid;

    // Reads are budgeted against buffer space including the word still in flight.
    always_comb begin
        state_d = state_q;
        rd      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.i_obuf_almostempty) state_d = StStream;
            end
            StStream: begin
                rd = !bus.i_obuf_empty && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)      occ_d = occ_q + 2'd1;
        else if (!push && pop) occ_d = occ_q - 2'd1;
    end

    always_ff @(posedge i_clk) begin
        if (clear) begin
            state_q      <= StIdle;
            head_q       <= 2'd0;
            tail_q       <= 2'd0;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 9'd0;
            frame_done_q <= 1'b0;
            starve_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd;
            occ_q      <= occ_d;
            if (push) tail_q <= inc3(tail_q);
            if (pop) begin
                head_q <= inc3(head_q);
                if (x_last) begin
                    x_q <= 10'd0;
                    y_q <= y_last ? 9'd0 : y_q + 9'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
            frame_done_q <= pop && x_last && y_last;
            if (starve && (starve_q != 16'hFFFF)) starve_q <= starve_q + 16'd1;
        end
    end

    // Payload storage needs no reset; validity is tracked by occ_q alone.
    always_ff @(posedge i_clk) begin
        if (push) buf_q[tail_q] <= bus.i_obuf_data;
    end

    assign bus.o_obuf_rd = rd;
    assign bus.o_tvalid  = valid;
    assign bus.o_tdata   = valid ? buf_q[head_q] : 16'd0;
    assign bus.o_tuser   = valid && (x_q == 10'd0) && (y_q == 9'd0);
    assign bus.o_tlast   = valid && x_last;
    assign o_frame_done  = frame_done_q;
    assign o_starve_cnt  = starve_q;

endmodule
